fb_scanout: RTL and testbench
=============================

// Module: fb_scanout
// PURPOSE
//  Read side of the CHIP-8 framebuffer RAM. The copy engine writes 64x32 mono pixels, 8 px/byte, MSB = leftmost.
//  Framebuffer address = {row[4:0], 2'b00, byte[2:0]}; rows are on a 32-byte stride and bytes 8..31 of each row are unused.
//  This block reads the RAM continuously and emits 640x480@60 VGA. Each CHIP-8 pixel is shown as a 10x10 block.
//  The 640x320 image is letterboxed with 80 lines above and 80 lines below.
//  The vblank/frame_start outputs let the top level start the copy engine outside the visible window, which avoids tearing.
// PARAMETERS
//  H_VISIBLE 640  active pixels/line
//  H_FRONT   16   h front porch
//  H_SYNC    96   h sync width
//  H_BACK    48   h back porch (line = 800 clk)
//  V_VISIBLE 480  active lines
//  V_FRONT   10   v front porch
//  V_SYNC    2    v sync width
//  V_BACK    33   v back porch (frame = 525 lines)
//  SCALE     10   clk per CHIP-8 pixel, horizontal and vertical
//  V_OFFSET  80   first line of image window
//  FG_COLOR  3'b111  rgb for lit pixel
//  BG_COLOR  3'b000  rgb for unlit pixel inside window
// PORTS
//  clk              in   1   pixel clock (25.175 MHz)
//  reset            in   1   synchronous, active-high
//  fb_read_address  out  10  framebuffer RAM read address
//  fb_ram_out       in   8   framebuffer RAM data, 1-cycle registered read latency
//  hsync            out  1   active-low
//  vsync            out  1   active-low
//  rgb              out  3   {r,g,b}
//  vblank           out  1   high while line >= V_VISIBLE
//  frame_start      out  1   1-clk pulse at first vblank clock of each frame
// BEHAVIOUR
//  - Reset values: hsync=1, vsync=1, rgb=0, vblank=0, frame_start=0, fb_read_address=0.
//    Reset also clears h/v counters and all pipeline stages.
//  - Counters: h 0..799, wraps to 0. v increments when h wraps; v 0..524, wraps to 0.
//  - Sub-counters: h_sub 0..SCALE-1 -> px_x 0..63, and v_sub -> px_y 0..31. No dividers.
//    px_x/h_sub clear at h=0. px_y/v_sub clear when v wraps and while v < V_OFFSET.
//  - Stage 0 (counter state): fb_read_address = {px_y, 2'b00, px_x[5:3]}. Address updates every clk and is don't-care outside the window.
//  - Stage 1: RAM data returns. Selected bit = fb_ram_out[7 - px_x[2:0]], using px_x delayed by 1.
//  - Stage 2 (registered outputs): hsync, vsync, vblank, frame_start and rgb are all derived from stage-0 counters.
//    Each is delayed by exactly 2 clk so sync and pixels stay aligned. Total latency is 2 clk.
//  - hsync low for h in [656,751]. vsync low for v in [490,491].
//  - rgb:
//      h >= 640 or v >= 480            -> 0
//      v < 80 or v >= 400 (letterbox)  -> 0
//      otherwise                       -> bit ? FG_COLOR : BG_COLOR
//  - vblank = (v >= 480). frame_start = (v == 480 && h == 0).
//  - Wrap: line 524 / h 799 is followed directly by (0,0). No idle cycle.
//  - Concurrent write to the address being read: RAM returns old or new data. One-frame artefacts are acceptable.
//  - Reset mid-frame: outputs take reset values the next clk. Timing restarts at (0,0).
//    The first valid pixel appears 2 clk after reset deasserts.
// STRUCTURE
//  - Shared package chip8_display_pkg holds:
//      DISPLAY_W=64, DISPLAY_H=32
//      FB_ADDR_W=10, FB_ROW_STRIDE=32
//      the fb address-pack function, also used by the copy engine
//      the VGA 640x480 timing constants
//  - Sub-module vga_timing: h/v counters, raw sync, vblank, frame_start and active flags.
//  - The remaining logic in fb_scanout: scale counters, address pack, bit select and the 2-stage alignment pipe.
// TESTING (bench models a 1024x8 sync RAM)
//  1. Assert reset for 3 clk -> hsync=1, vsync=1, rgb=0, vblank=0, frame_start=0. After deassert, fb_read_address=0x000.
//  2. Run 2 lines -> hsync period 800 clk; low for 96 clk starting 658 clk after line start (656+2).
//  3. Run 2 frames -> frame period 420000 clk; vsync low for 1600 clk.
//     frame_start pulses exactly once per frame at line 480; vblank high for 45 lines.
//  4. RAM all 0 except addr 0x000=0x80 -> rgb=FG only at h 0..9, v 80..89 (after 2-clk latency).
//     BG elsewhere in v 80..399; 0 in the letterbox and in blanking.
//  5. RAM addr 0x3E7=0x01 (row 31, byte 7, bit 0 = x 63) -> FG only at h 630..639, v 390..399.
//     The unused stride bytes (e.g. 0x3E8=0xFF) are never visible.
//  6. Reset asserted at line 100, h=300 -> outputs at reset values the next clk.
//     After release, hsync goes low at clk 658 and the line-80 image starts at line 80 of the new frame.

Source files
------------

// File: rtl/chip8_display_pkg.sv
// Shared CHIP-8 display definitions: framebuffer geometry, address packing
// and the 640x480@60 VGA raster timing used by the scan-out path.
package chip8_display_pkg;

  // CHIP-8 screen and framebuffer RAM geometry
  localparam int DISPLAY_W     = 64;
  localparam int DISPLAY_H     = 32;
  localparam int FB_ADDR_W     = 10;
  localparam int FB_ROW_STRIDE = 32;
  localparam int PX_X_W        = $clog2(DISPLAY_W);
  localparam int PX_Y_W        = $clog2(DISPLAY_H);
  // Zero bits between row and byte index: a row holds 8 used bytes in a 32-byte slot
  localparam int ROW_PAD_W     = $clog2(FB_ROW_STRIDE) - 3;

  typedef logic [PX_X_W-1:0] px_x_t;
  typedef logic [PX_Y_W-1:0] px_y_t;

  // VGA 640x480@60 timing
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Pixel scaling and letterbox placement
  localparam int SCALE    = 10;
  localparam int V_OFFSET = 80;

  localparam int H_CNT_W = 10;
  localparam int V_CNT_W = 10;
  localparam int SUB_W   = 4;
  typedef logic [H_CNT_W-1:0] hcnt_t;
  typedef logic [V_CNT_W-1:0] vcnt_t;
  typedef logic [SUB_W-1:0]   sub_t;

  // Counter compare points, sized to the counters they are compared against
  localparam hcnt_t H_ACTIVE_END = hcnt_t'(H_VISIBLE);
  localparam hcnt_t H_SYNC_BEGIN = hcnt_t'(H_VISIBLE + H_FRONT);
  localparam hcnt_t H_SYNC_LAST  = hcnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam hcnt_t H_LAST       = hcnt_t'(H_TOTAL - 1);
  localparam vcnt_t V_ACTIVE_END = vcnt_t'(V_VISIBLE);
  localparam vcnt_t V_SYNC_BEGIN = vcnt_t'(V_VISIBLE + V_FRONT);
  localparam vcnt_t V_SYNC_LAST  = vcnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam vcnt_t V_LAST       = vcnt_t'(V_TOTAL - 1);
  localparam vcnt_t V_IMG_BEGIN  = vcnt_t'(V_OFFSET);
  localparam vcnt_t V_IMG_END    = vcnt_t'(V_OFFSET + DISPLAY_H * SCALE);
  localparam sub_t  SUB_LAST     = sub_t'(SCALE - 1);

  typedef logic [2:0] rgb_t;
  localparam rgb_t FG_COLOR = 3'b111;
  localparam rgb_t BG_COLOR = 3'b000;

  // Sync/status bundle carried through the alignment pipe
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic vblank;
    logic frame_start;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, vblank: 1'b0, frame_start: 1'b0};

  // Framebuffer byte address for a CHIP-8 row and byte column (shared with the copy engine)
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input px_y_t row, input logic [2:0] byte_idx);
    return {row, {ROW_PAD_W{1'b0}}, byte_idx};
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer RAM read port: scan-out drives the address, the RAM returns
// the addressed byte one clock later.
interface fb_scanout_if;
  import chip8_display_pkg::*;

  logic [FB_ADDR_W-1:0] fb_read_address;
  logic [7:0]           fb_ram_out;

  modport master (output fb_read_address, input  fb_ram_out);
  modport slave  (input  fb_read_address, output fb_ram_out);
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster generator: free-running h/v counters plus the raw
// (unpipelined) sync, blanking and frame-start flags for the current position.
module vga_timing
  import chip8_display_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  output vcnt_t v,
  output logic  line_end,
  output logic  frame_end,
  output logic  active,
  output sync_t sync_raw
);

  hcnt_t h_q, h_d;
  vcnt_t v_q, v_d;

  // Next raster position: h wraps every line, v advances on each h wrap
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    h_d = h_q + hcnt_t'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + vcnt_t'(1);
    end
  end

  // Raster counter registers
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Raw flags for the current raster position
  always_comb begin
    sync_raw             = SYNC_IDLE;
    sync_raw.hsync       = !((h_q >= H_SYNC_BEGIN) && (h_q <= H_SYNC_LAST));
    sync_raw.vsync       = !((v_q >= V_SYNC_BEGIN) && (v_q <= V_SYNC_LAST));
    sync_raw.vblank      = (v_q >= V_ACTIVE_END);
    sync_raw.frame_start = (v_q == V_ACTIVE_END) && (h_q == '0);
  end

  assign v         = v_q;
  assign line_end  = (h_q == H_LAST);
  assign frame_end = line_end && (v_q == V_LAST);
  assign active    = (h_q < H_ACTIVE_END) && (v_q < V_ACTIVE_END);

endmodule

// File: rtl/fb_scanout.sv
// CHIP-8 framebuffer scan-out: walks the 64x32 image at 10x10 scale inside a
// letterboxed 640x480 raster, fetches one byte per 8 pixels and aligns sync
// and pixel data through a 2-clock pipe.
module fb_scanout
  import chip8_display_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  fb_scanout_if.master    fb,
  output logic            hsync,
  output logic            vsync,
  output logic [2:0]      rgb,
  output logic            vblank,
  output logic            frame_start
);

  vcnt_t v;
  logic  line_end;
  logic  frame_end;
  logic  active;
  sync_t sync_raw;

  vga_timing u_timing (
    .clk       (clk),
    .reset     (reset),
    .v         (v),
    .line_end  (line_end),
    .frame_end (frame_end),
    .active    (active),
    .sync_raw  (sync_raw)
  );

  // Stage 0: scale counters map raster position to CHIP-8 pixel coordinates
  sub_t  h_sub_q, h_sub_d;
  sub_t  v_sub_q, v_sub_d;
  px_x_t px_x_q,  px_x_d;
  px_y_t px_y_q,  px_y_d;

  // Stage 1: RAM data arrives; hold the bit index and window flag that go with it
  sync_t      sync1_q, sync1_d;
  logic       win1_q,  win1_d;
  logic [2:0] sel1_q,  sel1_d;

  // Stage 2: registered outputs
  sync_t sync2_q, sync2_d;
  rgb_t  rgb_q,   rgb_d;

  logic win0;
  logic pix_bit;

  // Scale counters: x restarts every line; y is held at 0 above the image and on frame wrap
  always_comb begin
    h_sub_d = h_sub_q;
    px_x_d  = px_x_q;
    v_sub_d = v_sub_q;
    px_y_d  = px_y_q;
    if (line_end) begin
      h_sub_d = '0;
      px_x_d  = '0;
      if (frame_end || (v < V_IMG_BEGIN)) begin
        v_sub_d = '0;
        px_y_d  = '0;
      end else if (v_sub_q == SUB_LAST) begin
        v_sub_d = '0;
        px_y_d  = px_y_q + px_y_t'(1);
      end else begin
        v_sub_d = v_sub_q + sub_t'(1);
      end
    end else if (h_sub_q == SUB_LAST) begin
      h_sub_d = '0;
      px_x_d  = px_x_q + px_x_t'(1);
    end else begin
      h_sub_d = h_sub_q + sub_t'(1);
    end
  end

  // Address is a pure function of stage-0 state, so it is 0 whenever the counters are cleared
  assign fb.fb_read_address = fb_addr(px_y_q, px_x_q[5:3]);

  assign win0    = active && (v >= V_IMG_BEGIN) && (v < V_IMG_END);
  assign pix_bit = fb.fb_ram_out[3'd7 - sel1_q];

  // Alignment pipe: sync flags travel two stages to meet the pixel colour
  always_comb begin
    sync1_d = sync_raw;
    win1_d  = win0;
    sel1_d  = px_x_q[2:0];
    sync2_d = sync1_q;
    rgb_d   = '0;
    if (win1_q) begin
      rgb_d = pix_bit ? FG_COLOR : BG_COLOR;
    end
  end

  // Scale counters and pipeline registers; reset idles sync and blanks the pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      h_sub_q <= '0;
      px_x_q  <= '0;
      v_sub_q <= '0;
      px_y_q  <= '0;
      sync1_q <= SYNC_IDLE;
      win1_q  <= 1'b0;
      sel1_q  <= '0;
      sync2_q <= SYNC_IDLE;
      rgb_q   <= '0;
    end else begin
      h_sub_q <= h_sub_d;
      px_x_q  <= px_x_d;
      v_sub_q <= v_sub_d;
      px_y_q  <= px_y_d;
      sync1_q <= sync1_d;
      win1_q  <= win1_d;
      sel1_q  <= sel1_d;
      sync2_q <= sync2_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync       = sync2_q.hsync;
  assign vsync       = sync2_q.vsync;
  assign vblank      = sync2_q.vblank;
  assign frame_start = sync2_q.frame_start;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: 1024x8 registered-read RAM model, directed spot checks
// at hand-computed clock indices, and a per-clock reference raster compared
// against every output while reset is low.
module tb_fb_scanout;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
  logic       vblank;
  logic       frame_start;

  fb_scanout_if bus ();

  logic [7:0] mem [0:1023];
  logic [7:0] ram_q;

  // k = number of rising edges since reset was released
  int k = 0;
  int n_checks = 0;
  int n_fail   = 0;

  int hs_err = 0, vs_err = 0, vb_err = 0, fs_err = 0, rgb_err = 0;
  int fs_cnt = 0;
  int first_bad_k = -1;

  // Image spot checks: index k = v*800 + h + 2, expected rgb
  localparam int N_SPOT = 12;
  localparam int SPOT_K   [N_SPOT] = '{63202, 64002, 64011, 64012, 71211, 72002,
                                       311837, 312632, 319831, 319841, 319842, 320637};
  localparam int SPOT_RGB [N_SPOT] = '{0, 7, 7, 0, 7, 0,
                                       0, 7, 0, 7, 0, 0};

  initial forever #5 clk = ~clk;

  fb_scanout dut (
    .clk         (clk),
    .reset       (reset),
    .fb          (bus),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  always @(posedge clk) ram_q <= mem[bus.fb_read_address];
  assign bus.fb_ram_out = ram_q;

  always @(posedge clk) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference raster: outputs seen after edge kk describe position kk-2
  task automatic model(input int kk, output logic hs, output logic vs, output logic vb,
                       output logic fs, output logic [2:0] c);
    int p, h, v, x, y;
    logic [7:0] b;
    hs = 1'b1; vs = 1'b1; vb = 1'b0; fs = 1'b0; c = 3'b000;
    if (kk >= 2) begin
      p  = kk - 2;
      h  = p % 800;
      v  = (p / 800) % 525;
      hs = !(h >= 656 && h <= 751);
      vs = !(v == 490 || v == 491);
      vb = (v >= 480);
      fs = (v == 480 && h == 0);
      if (h < 640 && v >= 80 && v < 400) begin
        x = h / 10;
        y = (v - 80) / 10;
        b = mem[y * 32 + x / 8];
        c = b[7 - x % 8] ? 3'b111 : 3'b000;
      end
    end
  endtask

  // Stream monitor: compares every clock against the reference raster
  initial forever begin
    logic e_hs, e_vs, e_vb, e_fs;
    logic [2:0] e_rgb;
    @(negedge clk);
    #1;
    if (reset === 1'b0) begin
      model(k, e_hs, e_vs, e_vb, e_fs, e_rgb);
      if (hsync !== e_hs)       begin hs_err++;  if (first_bad_k < 0) first_bad_k = k; end
      if (vsync !== e_vs)       begin vs_err++;  if (first_bad_k < 0) first_bad_k = k; end
      if (vblank !== e_vb)      begin vb_err++;  if (first_bad_k < 0) first_bad_k = k; end
      if (frame_start !== e_fs) begin fs_err++;  if (first_bad_k < 0) first_bad_k = k; end
      if (rgb !== e_rgb)        begin rgb_err++; if (first_bad_k < 0) first_bad_k = k; end
      if (frame_start === 1'b1) fs_cnt++;
    end else begin
      fs_cnt = 0;
    end
  end

  // Advance to the falling edge where k == target; bounded
  task automatic wait_k(input int target);
    int guard = 0;
    while (k < target && guard < 900000) begin
      @(negedge clk);
      guard++;
    end
    if (k != target) check($sformatf("wait_k_%0d", target), 32'(k), 32'(target));
  endtask

  task automatic check_reset_values(input string ph);
    check({ph, "_hsync"},       32'(hsync),       32'd1);
    check({ph, "_vsync"},       32'(vsync),       32'd1);
    check({ph, "_rgb"},         32'(rgb),         32'd0);
    check({ph, "_vblank"},      32'(vblank),      32'd0);
    check({ph, "_frame_start"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h000] = 8'h80;   // pixel (0,0)
    mem[10'h3E7] = 8'h01;   // pixel (63,31)
    mem[10'h3E8] = 8'hFF;   // unused stride bytes: must never show
    mem[10'h01F] = 8'hFF;
    mem[10'h008] = 8'hFF;

    // Initial reset held for 3 clocks
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    #1;
    check("rst_addr", 32'(bus.fb_read_address), 32'h000);

    // First two lines: hsync low 656..751 seen 2 clocks late, period 800
    wait_k(657);  check("hs_l0_before", 32'(hsync), 32'd1);
    wait_k(658);  check("hs_l0_fall",   32'(hsync), 32'd0);
    wait_k(753);  check("hs_l0_last",   32'(hsync), 32'd0);
    wait_k(754);  check("hs_l0_rise",   32'(hsync), 32'd1);
    wait_k(1457); check("hs_l1_before", 32'(hsync), 32'd1);
    wait_k(1458); check("hs_l1_fall",   32'(hsync), 32'd0);

    // Reset mid-frame at line 100, h 300
    wait_k(80300);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_rst");
    check("mid_rst_addr", 32'(bus.fb_read_address), 32'h000);
    reset = 1'b0;

    // New frame from (0,0)
    wait_k(657); check("hs_new_before", 32'(hsync), 32'd1);
    wait_k(658); check("hs_new_fall",   32'(hsync), 32'd0);

    for (int i = 0; i < N_SPOT; i++) begin
      wait_k(SPOT_K[i]);
      check($sformatf("rgb_k%0d", SPOT_K[i]), 32'(rgb), 32'(SPOT_RGB[i]));
    end

    wait_k(384001); check("vb_before", 32'(vblank), 32'd0);
                    check("fs_before", 32'(frame_start), 32'd0);
    wait_k(384002); check("vb_rise",   32'(vblank), 32'd1);
                    check("fs_pulse",  32'(frame_start), 32'd1);
    wait_k(384003); check("fs_after",  32'(frame_start), 32'd0);
    wait_k(392001); check("vs_before", 32'(vsync), 32'd1);
    wait_k(392002); check("vs_fall",   32'(vsync), 32'd0);
    wait_k(393601); check("vs_last",   32'(vsync), 32'd0);
    wait_k(393602); check("vs_rise",   32'(vsync), 32'd1);
    wait_k(420001); check("vb_last",   32'(vblank), 32'd1);
    wait_k(420002); check("vb_fall",   32'(vblank), 32'd0);
    wait_k(484007); check("rgb_frame2_px00", 32'(rgb), 32'd7);
    wait_k(804001); check("fs2_before", 32'(frame_start), 32'd0);
    wait_k(804002); check("fs2_pulse",  32'(frame_start), 32'd1);
    wait_k(804010); check("fs_count",   32'(fs_cnt), 32'd2);

    check($sformatf("stream_hsync first_bad_k=%0d", first_bad_k),  32'(hs_err),  32'd0);
    check($sformatf("stream_vsync first_bad_k=%0d", first_bad_k),  32'(vs_err),  32'd0);
    check($sformatf("stream_vblank first_bad_k=%0d", first_bad_k), 32'(vb_err),  32'd0);
    check($sformatf("stream_fstart first_bad_k=%0d", first_bad_k), 32'(fs_err),  32'd0);
    check($sformatf("stream_rgb first_bad_k=%0d", first_bad_k),    32'(rgb_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
